// File: rtl/chaotic_lfsr_seeder_if.sv
// Sample-in / random-out handshake bundle for chaotic_lfsr_seeder.
// master = environment (sample source, output sink), slave = the seeder.
interface chaotic_lfsr_seeder_if #(
   parameter int LFSR_W = 16
);
   logic [15:0]       x_in;
   logic              x_valid;
   logic              x_ready;
   logic [LFSR_W-1:0] rnd_out;
   logic              rnd_valid;
   logic              out_ready;
   logic              reseed_done;

   modport master (
      output x_in, x_valid, out_ready,
      input  x_ready, rnd_out, rnd_valid, reseed_done
   );

   modport slave (
      input  x_in, x_valid, out_ready,
      output x_ready, rnd_out, rnd_valid, reseed_done
   );
endinterface

// File: rtl/chaotic_lfsr_seeder.sv
// Packs low bits of chaotic Q1.15 samples into a seed for a Galois LFSR and
// streams LFSR states, re-seeding every RESEED_PERIOD output handshakes.
module chaotic_lfsr_seeder #(
   parameter int                LFSR_W          = 16,
   parameter logic [LFSR_W-1:0] TAPS            = 16'hB400,
   parameter int                BITS_PER_SAMPLE = 4,
   parameter int                RESEED_PERIOD   = 256,
   parameter logic [LFSR_W-1:0] DEFAULT_SEED    = 16'h0001
) (
   input logic                  clk,
   input logic                  reset,
   chaotic_lfsr_seeder_if.slave bus
);
   localparam int NS     = LFSR_W / BITS_PER_SAMPLE;
   localparam int CNT_W  = $clog2(NS + 1);
   localparam int STEP_W = $clog2(RESEED_PERIOD);

   localparam logic [0:0] COLLECT = 1'b0;
   localparam logic [0:0] RUN     = 1'b1;

   logic [0:0]        state;
   logic [LFSR_W-1:0] lfsr;
   logic [LFSR_W-1:0] seed_buf;
   logic [CNT_W-1:0]  samp_cnt;
   logic [STEP_W-1:0] step_cnt;
   logic              rnd_valid_q;
   logic              reseed_done_q;

   logic              seed_full;
   logic              period_end;
   logic              load_seed;
   logic [LFSR_W-1:0] seed_val;
   logic [LFSR_W-1:0] lfsr_next;

   // Sign and upper magnitude bits are deliberately discarded.
   logic unused_upper_bits;
   assign unused_upper_bits = &{1'b0, bus.x_in[15:BITS_PER_SAMPLE]};

   always_comb begin
      seed_full  = (samp_cnt == CNT_W'(NS));
      seed_val   = (seed_buf != '0) ? seed_buf : DEFAULT_SEED;
      lfsr_next  = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
      period_end = (state == RUN) && bus.out_ready &&
                   (step_cnt == STEP_W'(RESEED_PERIOD - 1));
      load_seed  = seed_full && ((state == COLLECT) || period_end);
   end

   assign bus.x_ready     = !seed_full;
   assign bus.rnd_out     = lfsr;
   assign bus.rnd_valid   = rnd_valid_q;
   assign bus.reseed_done = reseed_done_q;

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would chain updates in order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= COLLECT;
         lfsr          <= DEFAULT_SEED;
         seed_buf      <= '0;
         samp_cnt      <= '0;
         step_cnt      <= '0;
         rnd_valid_q   <= 1'b0;
         reseed_done_q <= 1'b0;
      end else begin
         reseed_done_q <= load_seed;

         // Background collection; a load empties the buffer on the same edge.
         if (load_seed) begin
            seed_buf <= '0;
            samp_cnt <= '0;
         end else if (bus.x_valid && !seed_full) begin
            seed_buf <= {seed_buf[LFSR_W-BITS_PER_SAMPLE-1:0],
                         bus.x_in[BITS_PER_SAMPLE-1:0]};
            samp_cnt <= samp_cnt + CNT_W'(1);
         end

         if (state == COLLECT) begin
            if (seed_full) begin
               lfsr        <= seed_val;
               step_cnt    <= '0;
               state       <= RUN;
               rnd_valid_q <= 1'b1;
            end
         end else if (bus.out_ready) begin
            if (period_end) begin
               step_cnt <= '0;
               if (seed_full) begin
                  lfsr <= seed_val;
               end else begin
                  state       <= COLLECT;
                  rnd_valid_q <= 1'b0;
               end
            end else begin
               lfsr     <= lfsr_next;
               step_cnt <= step_cnt + STEP_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_chaotic_lfsr_seeder.sv
// Self-checking bench for chaotic_lfsr_seeder: table-driven seed vectors,
// scoreboard of expected output words, plus re-seed, hold and reset sequences.
module tb_chaotic_lfsr_seeder;
   localparam int PERIOD = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   chaotic_lfsr_seeder_if #(.LFSR_W(16)) bus ();

   chaotic_lfsr_seeder #(
      .LFSR_W         (16),
      .TAPS           (16'hB400),
      .BITS_PER_SAMPLE(4),
      .RESEED_PERIOD  (PERIOD),
      .DEFAULT_SEED   (16'h0001)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      string       name;
      logic [15:0] samp  [4];
      logic [15:0] words [4];
   } vec_t;

   vec_t        vecs [5];
   logic [15:0] sb_q [$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          rd_cnt  = 0;
   int          gap_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Every output handshake pops one expected word; reseed pulses are counted.
   always @(negedge clk) begin
      if (bus.reseed_done) rd_cnt++;
      if (bus.rnd_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_pop: unexpected rnd_out 0x%04h, nothing expected", bus.rnd_out);
         end else begin
            check("rnd_out", 32'(bus.rnd_out), 32'(sb_q.pop_front()));
         end
      end else if (!bus.rnd_valid && sb_q.size() != 0) begin
         gap_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      tick(1);
      reset         = 1'b0;
      bus.x_valid   = 1'b0;
      bus.x_in      = '0;
      bus.out_ready = 1'b0;
      sb_q.delete();
      tick(1);
      #2 reset = 1'b1;
      tick(1);
      rd_cnt  = 0;
      gap_cnt = 0;
   endtask

   task automatic send_samples(input logic [15:0] s [4], input logic [15:0] words [4]);
      for (int i = 0; i < 4; i++) begin
         int b;
         b = 0;
         bus.x_in    = s[i];
         bus.x_valid = 1'b1;
         @(negedge clk);
         while (!bus.x_ready && b < 50) begin
            b++;
            @(negedge clk);
         end
         if (b >= 50) timeout("x_ready_wait");
         @(posedge clk);
         #1;
      end
      bus.x_valid = 1'b0;
      for (int i = 0; i < 4; i++) sb_q.push_back(words[i]);
   endtask

   task automatic wait_drain(input int target);
      int b;
      b = 0;
      while (sb_q.size() > target && b < 300) begin
         @(posedge clk);
         b++;
      end
      #1;
      if (b >= 300) timeout("drain");
   endtask

   task automatic wait_reseed(input int n);
      int b;
      b = 0;
      while (rd_cnt < n && b < 50) begin
         @(posedge clk);
         b++;
      end
      #1;
      if (b >= 50) timeout("reseed_wait");
   endtask

   initial begin
      bus.x_in      = '0;
      bus.x_valid   = 1'b0;
      bus.out_ready = 1'b0;

      vecs[0].name  = "nibbles_1234";
      vecs[0].samp  = '{16'h1231, 16'h0452, 16'h7FF3, 16'h8004};
      vecs[0].words = '{16'h1234, 16'h091A, 16'h048D, 16'hB646};
      vecs[1].name  = "seed_0001";
      vecs[1].samp  = '{16'h0000, 16'h0000, 16'h0000, 16'h0001};
      vecs[1].words = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00};
      vecs[2].name  = "zero_seed_default";
      vecs[2].samp  = '{16'h0010, 16'h0FF0, 16'hFFF0, 16'h8000};
      vecs[2].words = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00};
      vecs[3].name  = "seed_0123";
      vecs[3].samp  = '{16'h00A0, 16'h00B1, 16'h00C2, 16'h00D3};
      vecs[3].words = '{16'h0123, 16'hB491, 16'hEE48, 16'h7724};
      vecs[4].name  = "seed_ffff";
      vecs[4].samp  = '{16'hFFFF, 16'h7FFF, 16'h800F, 16'h000F};
      vecs[4].words = '{16'hFFFF, 16'hCBFF, 16'hD1FF, 16'hDCFF};

      // Table: each seed from reset, one full period, then back to COLLECT.
      for (int v = 0; v < 5; v++) begin
         apply_reset();
         check({vecs[v].name, "_rst_valid"}, 32'(bus.rnd_valid), 32'd0);
         check({vecs[v].name, "_rst_xready"}, 32'(bus.x_ready), 32'd1);
         check({vecs[v].name, "_rst_done"}, 32'(bus.reseed_done), 32'd0);
         bus.out_ready = 1'b1;
         send_samples(vecs[v].samp, vecs[v].words);
         wait_drain(0);
         tick(1);
         check({vecs[v].name, "_load_latency"}, 32'(gap_cnt), 32'd1);
         check({vecs[v].name, "_reseed_cnt"}, 32'(rd_cnt), 32'd1);
         check({vecs[v].name, "_valid_drop"}, 32'(bus.rnd_valid), 32'd0);
      end

      // Pre-collected seed under backpressure, then seamless re-seed.
      apply_reset();
      send_samples(vecs[0].samp, vecs[0].words);
      wait_reseed(1);
      check("hold_first_word", 32'(bus.rnd_out), 32'h1234);
      send_samples(vecs[3].samp, vecs[3].words);
      check("x_ready_full", 32'(bus.x_ready), 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("hold_rnd_out", 32'(bus.rnd_out), 32'h1234);
         check("hold_rnd_valid", 32'(bus.rnd_valid), 32'd1);
      end
      gap_cnt       = 0;
      bus.out_ready = 1'b1;
      wait_drain(0);
      tick(1);
      check("no_bubble", 32'(gap_cnt), 32'd0);
      check("reseed_cnt_2", 32'(rd_cnt), 32'd2);
      check("collect_valid", 32'(bus.rnd_valid), 32'd0);
      check("collect_xready", 32'(bus.x_ready), 32'd1);
      tick(5);
      check("starved_valid", 32'(bus.rnd_valid), 32'd0);
      send_samples(vecs[1].samp, vecs[1].words);
      wait_drain(0);
      check("reseed_cnt_3", 32'(rd_cnt), 32'd3);

      // Asynchronous reset mid-run with a partial seed collected.
      apply_reset();
      bus.out_ready = 1'b1;
      send_samples(vecs[4].samp, vecs[4].words);
      wait_drain(2);
      bus.out_ready = 1'b0;
      bus.x_in      = 16'h000F;
      bus.x_valid   = 1'b1;
      tick(2);
      bus.x_valid   = 1'b0;
      #1 reset = 1'b0;
      #1;
      check("async_rst_valid", 32'(bus.rnd_valid), 32'd0);
      check("async_rst_xready", 32'(bus.x_ready), 32'd1);
      check("async_rst_done", 32'(bus.reseed_done), 32'd0);
      sb_q.delete();
      tick(2);
      #3 reset = 1'b1;
      tick(1);
      rd_cnt        = 0;
      bus.out_ready = 1'b1;
      send_samples(vecs[1].samp, vecs[1].words);
      wait_drain(0);
      tick(1);
      check("post_rst_reseed_cnt", 32'(rd_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
